// File: rtl/tile_framebuffer_if.sv
// Host and video bundle for the tile framebuffer.
// Covers timing inputs, RGB output, write port and fill controls.
interface tile_framebuffer_if #(
    parameter int COLOR_W = 3,
    parameter int POS_W   = 10
);
    logic [POS_W-1:0]     hpos;
    logic [POS_W-1:0]     vpos;
    logic                 display_on;
    logic [COLOR_W-1:0]   rgb;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [7:0]           wr_x;
    logic [7:0]           wr_y;
    logic [COLOR_W-1:0]   wr_color;
    logic                 wr_err;
    logic                 fill_start;
    logic                 fill_mode;
    logic [COLOR_W-1:0]   fill_color;
    logic [3*COLOR_W-1:0] band_colors;
    logic                 fill_busy;
    logic                 fill_done;

    modport master (
        output hpos, vpos, display_on,
        output wr_valid, wr_x, wr_y, wr_color,
        output fill_start, fill_mode, fill_color, band_colors,
        input  rgb, wr_ready, wr_err, fill_busy, fill_done
    );

    modport slave (
        input  hpos, vpos, display_on,
        input  wr_valid, wr_x, wr_y, wr_color,
        input  fill_start, fill_mode, fill_color, band_colors,
        output rgb, wr_ready, wr_err, fill_busy, fill_done
    );
endinterface

// File: rtl/tile_framebuffer.sv
// Character-cell video memory with host write port and fill engine.
// Two-stage scanout: cell coordinates, then RAM read into rgb.
module tile_framebuffer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int CELL_SHIFT = 3,
    parameter int COLOR_W    = 3,
    parameter int POS_W      = 10
) (
    input logic               clk,
    input logic               rst_n,
    tile_framebuffer_if.slave bus
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int CW    = POS_W - CELL_SHIFT;
    localparam int BAND  = ROWS / 3;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t               state_q, state_d;
    logic [XW-1:0]        fx_q, fx_d;
    logic [YW-1:0]        fy_q, fy_d;
    logic                 mode_q, mode_d;
    logic [COLOR_W-1:0]   fcol_q, fcol_d;
    logic [3*COLOR_W-1:0] bands_q, bands_d;
    logic                 wr_err_q;

    logic [COLOR_W-1:0] mem [DEPTH];

    logic               fill_we;
    logic [COLOR_W-1:0] fill_px;
    logic               host_acc;
    logic               host_rng;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [COLOR_W-1:0] wdata;

    always_comb begin
        state_d = state_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        mode_d  = mode_q;
        fcol_d  = fcol_q;
        bands_d = bands_q;
        fill_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fill_start) begin
                    mode_d  = bus.fill_mode;
                    fcol_d  = bus.fill_color;
                    bands_d = bus.band_colors;
                    fx_d    = '0;
                    fy_d    = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_we = 1'b1;
                if (fx_q == XW'(COLS - 1)) begin
                    fx_d = '0;
                    if (fy_q == YW'(ROWS - 1)) state_d = DONE;
                    else fy_d = fy_q + 1'b1;
                end else begin
                    fx_d = fx_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_px = fcol_q;
        if (mode_q) begin
            if (int'(fy_q) < BAND)
                fill_px = bands_q[COLOR_W-1:0];
            else if (int'(fy_q) < 2 * BAND)
                fill_px = bands_q[2*COLOR_W-1:COLOR_W];
            else
                fill_px = bands_q[3*COLOR_W-1:2*COLOR_W];
        end
    end

    // Host and fill never write together: the host is only served in IDLE.
    assign bus.wr_ready = (state_q == IDLE);
    assign host_acc = bus.wr_valid && bus.wr_ready;
    assign host_rng = (int'(bus.wr_x) < COLS) && (int'(bus.wr_y) < ROWS);
    assign we       = fill_we || (host_acc && host_rng);
    assign waddr    = fill_we ? AW'(int'(fy_q) * COLS + int'(fx_q))
                              : AW'(int'(bus.wr_y) * COLS + int'(bus.wr_x));
    assign wdata    = fill_we ? fill_px : bus.wr_color;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fx_q     <= '0;
            fy_q     <= '0;
            mode_q   <= 1'b0;
            fcol_q   <= '0;
            bands_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            mode_q   <= mode_d;
            fcol_q   <= fcol_d;
            bands_q  <= bands_d;
            wr_err_q <= host_acc && !host_rng;
        end
    end

    logic [CW-1:0]      cx_q, cy_q;
    logic               rng_q, on_q;
    logic [COLOR_W-1:0] rgb_q;
    logic [AW-1:0]      raddr;

    // Out-of-grid cells read address 0; the result is masked anyway.
    assign raddr = rng_q ? AW'(int'(cy_q) * COLS + int'(cx_q)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q  <= '0;
            cy_q  <= '0;
            rng_q <= 1'b0;
            on_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            cx_q  <= CW'(bus.hpos >> CELL_SHIFT);
            cy_q  <= CW'(bus.vpos >> CELL_SHIFT);
            rng_q <= (int'(bus.hpos >> CELL_SHIFT) < COLS)
                  && (int'(bus.vpos >> CELL_SHIFT) < ROWS);
            on_q  <= bus.display_on;
            rgb_q <= (on_q && rng_q) ? mem[raddr] : '0;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.fill_busy = (state_q == FILL);
    assign bus.fill_done = (state_q == DONE);
endmodule

// File: tb/tb_tile_framebuffer.sv
// Directed bench for tile_framebuffer.
// Scenario tasks with inline checks, run from one initial block.
module tb_tile_framebuffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    tile_framebuffer_if #(.COLOR_W(3), .POS_W(10)) bus ();

    tile_framebuffer #(
        .COLS(80), .ROWS(60), .CELL_SHIFT(3), .COLOR_W(3), .POS_W(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int h, input int v, input logic on,
                         output logic [2:0] c);
        bus.hpos = 10'(h);
        bus.vpos = 10'(v);
        bus.display_on = on;
        @(posedge clk);
        @(posedge clk);
        #1;
        c = bus.rgb;
    endtask

    task automatic run_fill(input logic mode, input logic [2:0] col,
                            input logic [8:0] bands, output int cnt,
                            output logic done_seen, output logic done_after);
        bus.fill_mode = mode;
        bus.fill_color = col;
        bus.band_colors = bands;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        cnt = 0;
        while (bus.fill_busy && cnt < 6000) begin
            step();
            cnt++;
        end
        done_seen = bus.fill_done;
        step();
        done_after = bus.fill_done;
    endtask

    task automatic test_reset();
        logic [3:0] o;
        #12;
        o = {bus.rgb == 3'b000, bus.wr_err, bus.fill_busy, bus.fill_done};
        vec++;
        if (o !== 4'b1000) begin
            errs++;
            $display("FAIL reset_outs got %b want 1000", o);
        end
        vec++;
        if (bus.wr_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready got %b want 1", bus.wr_ready);
        end
        #5 rst_n = 1'b1;
        step();
    endtask

    task automatic test_solid_fill();
        int cnt;
        logic ds, da;
        logic [2:0] c;
        run_fill(1'b0, 3'b101, 9'h0, cnt, ds, da);
        vec++;
        if (cnt !== 4800) begin
            errs++;
            $display("FAIL solid_cycles got %0d want 4800", cnt);
        end
        vec++;
        if ({ds, da} !== 2'b10) begin
            errs++;
            $display("FAIL solid_done got %b want 10", {ds, da});
        end
        probe(0, 0, 1'b1, c);
        vec++;
        if (c !== 3'b101) begin
            errs++;
            $display("FAIL solid_px00 got %b want 101", c);
        end
        probe(639, 479, 1'b1, c);
        vec++;
        if (c !== 3'b101) begin
            errs++;
            $display("FAIL solid_pxlast got %b want 101", c);
        end
        probe(320, 240, 1'b1, c);
        vec++;
        if (c !== 3'b101) begin
            errs++;
            $display("FAIL solid_pxmid got %b want 101", c);
        end
    endtask

    task automatic test_band_fill();
        int cnt;
        logic ds, da;
        logic [2:0] c;
        run_fill(1'b1, 3'b000, {3'b100, 3'b001, 3'b111}, cnt, ds, da);
        vec++;
        if (cnt !== 4800 || {ds, da} !== 2'b10) begin
            errs++;
            $display("FAIL band_run got %0d/%b want 4800/10", cnt, {ds, da});
        end
        probe(10, 159, 1'b1, c);
        vec++;
        if (c !== 3'b111) begin
            errs++;
            $display("FAIL band_v159 got %b want 111", c);
        end
        probe(10, 160, 1'b1, c);
        vec++;
        if (c !== 3'b001) begin
            errs++;
            $display("FAIL band_v160 got %b want 001", c);
        end
        probe(10, 320, 1'b1, c);
        vec++;
        if (c !== 3'b100) begin
            errs++;
            $display("FAIL band_v320 got %b want 100", c);
        end
        probe(10, 319, 1'b1, c);
        vec++;
        if (c !== 3'b001) begin
            errs++;
            $display("FAIL band_v319 got %b want 001", c);
        end
        probe(639, 479, 1'b1, c);
        vec++;
        if (c !== 3'b100) begin
            errs++;
            $display("FAIL band_vlast got %b want 100", c);
        end
    endtask

    task automatic host_write(input int x, input int y, input logic [2:0] col,
                              output logic err, output logic err_next,
                              output logic ok);
        int n = 0;
        bus.wr_x = 8'(x);
        bus.wr_y = 8'(y);
        bus.wr_color = col;
        bus.wr_valid = 1'b1;
        while (!bus.wr_ready && n < 6000) begin
            step();
            n++;
        end
        ok = bus.wr_ready;
        step();
        bus.wr_valid = 1'b0;
        err = bus.wr_err;
        step();
        err_next = bus.wr_err;
    endtask

    task automatic test_host_write();
        logic e0, e1, ok;
        logic [2:0] c;
        host_write(79, 59, 3'b010, e0, e1, ok);
        vec++;
        if ({ok, e0, e1} !== 3'b100) begin
            errs++;
            $display("FAIL wr_ok got %b want 100", {ok, e0, e1});
        end
        probe(632, 472, 1'b1, c);
        vec++;
        if (c !== 3'b010) begin
            errs++;
            $display("FAIL wr_px632 got %b want 010", c);
        end
        probe(639, 479, 1'b1, c);
        vec++;
        if (c !== 3'b010) begin
            errs++;
            $display("FAIL wr_px639 got %b want 010", c);
        end
        probe(631, 479, 1'b1, c);
        vec++;
        if (c !== 3'b100) begin
            errs++;
            $display("FAIL wr_px631 got %b want 100", c);
        end
        host_write(80, 0, 3'b000, e0, e1, ok);
        vec++;
        if ({ok, e0, e1} !== 3'b110) begin
            errs++;
            $display("FAIL wr_oob_err got %b want 110", {ok, e0, e1});
        end
        probe(0, 8, 1'b1, c);
        vec++;
        if (c !== 3'b111) begin
            errs++;
            $display("FAIL wr_oob_cell80 got %b want 111", c);
        end
        probe(632, 0, 1'b1, c);
        vec++;
        if (c !== 3'b111) begin
            errs++;
            $display("FAIL wr_oob_cell79 got %b want 111", c);
        end
    endtask

    task automatic test_blanking();
        logic [2:0] c;
        probe(0, 0, 1'b0, c);
        vec++;
        if (c !== 3'b000) begin
            errs++;
            $display("FAIL blank_off got %b want 000", c);
        end
        probe(700, 0, 1'b1, c);
        vec++;
        if (c !== 3'b000) begin
            errs++;
            $display("FAIL blank_h700 got %b want 000", c);
        end
        probe(100, 480, 1'b1, c);
        vec++;
        if (c !== 3'b000) begin
            errs++;
            $display("FAIL blank_v480 got %b want 000", c);
        end
        probe(0, 0, 1'b1, c);
        vec++;
        if (c !== 3'b111) begin
            errs++;
            $display("FAIL blank_back got %b want 111", c);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int rdy = 0;
        logic [2:0] c;
        bus.fill_mode = 1'b0;
        bus.fill_color = 3'b110;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        bus.fill_mode = 1'b1;
        bus.fill_color = 3'b000;
        bus.wr_x = 8'd5;
        bus.wr_y = 8'd5;
        bus.wr_color = 3'b011;
        bus.wr_valid = 1'b1;
        while (bus.fill_busy && cnt < 6000) begin
            bus.fill_start = (cnt == 100);
            if (bus.wr_ready) rdy++;
            step();
            cnt++;
        end
        bus.fill_start = 1'b0;
        vec++;
        if (cnt !== 4800 || rdy !== 0) begin
            errs++;
            $display("FAIL b2b_run got %0d/%0d want 4800/0", cnt, rdy);
        end
        vec++;
        if ({bus.fill_done, bus.wr_ready} !== 2'b10) begin
            errs++;
            $display("FAIL b2b_done got %b want 10",
                     {bus.fill_done, bus.wr_ready});
        end
        step();
        vec++;
        if ({bus.wr_ready, bus.fill_busy} !== 2'b10) begin
            errs++;
            $display("FAIL b2b_idle got %b want 10",
                     {bus.wr_ready, bus.fill_busy});
        end
        step();
        bus.wr_valid = 1'b0;
        probe(40, 40, 1'b1, c);
        vec++;
        if (c !== 3'b011) begin
            errs++;
            $display("FAIL b2b_host got %b want 011", c);
        end
        probe(48, 40, 1'b1, c);
        vec++;
        if (c !== 3'b110) begin
            errs++;
            $display("FAIL b2b_fill got %b want 110", c);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cnt;
        logic ds, da;
        logic [2:0] c;
        bus.hpos = 10'd0;
        bus.vpos = 10'd0;
        bus.display_on = 1'b1;
        bus.fill_mode = 1'b0;
        bus.fill_color = 3'b001;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        repeat (1000) step();
        rst_n = 1'b0;
        #1;
        vec++;
        if ({bus.fill_busy, bus.fill_done, bus.wr_ready, bus.rgb} !== 6'b001000) begin
            errs++;
            $display("FAIL rst_async got %b want 001000",
                     {bus.fill_busy, bus.fill_done, bus.wr_ready, bus.rgb});
        end
        #2 rst_n = 1'b1;
        step();
        probe(312, 96, 1'b1, c);
        vec++;
        if (c !== 3'b001) begin
            errs++;
            $display("FAIL rst_cell999 got %b want 001", c);
        end
        probe(320, 96, 1'b1, c);
        vec++;
        if (c !== 3'b110) begin
            errs++;
            $display("FAIL rst_cell1000 got %b want 110", c);
        end
        probe(40, 40, 1'b1, c);
        vec++;
        if (c !== 3'b001) begin
            errs++;
            $display("FAIL rst_cell405 got %b want 001", c);
        end
        run_fill(1'b1, 3'b000, {3'b010, 3'b100, 3'b011}, cnt, ds, da);
        vec++;
        if (cnt !== 4800 || {ds, da} !== 2'b10) begin
            errs++;
            $display("FAIL refill_run got %0d/%b want 4800/10", cnt, {ds, da});
        end
        probe(0, 0, 1'b1, c);
        vec++;
        if (c !== 3'b011) begin
            errs++;
            $display("FAIL refill_top got %b want 011", c);
        end
        probe(400, 200, 1'b1, c);
        vec++;
        if (c !== 3'b100) begin
            errs++;
            $display("FAIL refill_mid got %b want 100", c);
        end
        probe(0, 479, 1'b1, c);
        vec++;
        if (c !== 3'b010) begin
            errs++;
            $display("FAIL refill_bot got %b want 010", c);
        end
    endtask

    initial begin
        bus.hpos = '0;
        bus.vpos = '0;
        bus.display_on = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_x = '0;
        bus.wr_y = '0;
        bus.wr_color = '0;
        bus.fill_start = 1'b0;
        bus.fill_mode = 1'b0;
        bus.fill_color = '0;
        bus.band_colors = '0;
        test_reset();
        test_solid_fill();
        test_band_fill();
        test_host_write();
        test_blanking();
        test_back_to_back();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/tile_framebuffer.md
Name: tile_framebuffer

Overview:
- Parametrised character-cell video memory: a COLS x ROWS grid of COLOR_W-bit cells, each cell covering a 2^CELL_SHIFT-pixel square on screen.
- Sits between the VGA timing generator (hpos/vpos/display_on) and the RGB pins. Replaces the hard-wired 80x60 3-bit cell buffer and its free-running painter.
- Adds a valid/ready host write port, linear addressing, out-of-range protection, and a hardware fill engine with solid and three-band modes.

Parameters:
COLS, 80, cells per row
ROWS, 60, cell rows
CELL_SHIFT, 3, log2 of cell edge in pixels (3 -> 8x8)
COLOR_W, 3, bits per cell / pixel
POS_W, 10, width of hpos/vpos

Ports:
clk  in  1  system clock (single domain; timing generator runs on the same clock)
rst_n  in  1  asynchronous active-low reset
hpos  in  POS_W  current pixel column from timing generator
vpos  in  POS_W  current pixel row from timing generator
display_on  in  1  active-video flag from timing generator
rgb  out  COLOR_W  pixel colour, registered
wr_valid  in  1  host write request
wr_ready  out  1  write port available
wr_x  in  8  target cell column
wr_y  in  8  target cell row
wr_color  in  COLOR_W  colour to store
wr_err  out  1  one-cycle pulse: accepted write was out of range and was dropped
fill_start  in  1  start a fill (pulse)
fill_mode  in  1  0 = solid fill_color; 1 = three horizontal bands
fill_color  in  COLOR_W  solid-mode colour
band_colors  in  3*COLOR_W  [COLOR_W-1:0] top, next field middle, top field bottom
fill_busy  out  1  fill engine running
fill_done  out  1  one-cycle pulse after the last fill write

Behaviour:
- Address = y*COLS + x, depth COLS*ROWS, single write port, single read port. Inferred RAM; contents are not reset.
- Reset values: rgb=0, wr_err=0, fill_busy=0, fill_done=0, wr_ready=1, FSM=IDLE, pipelines cleared.
- Scanout is a two-stage pipeline:
  - Stage 1 registers cx = hpos>>CELL_SHIFT, cy = vpos>>CELL_SHIFT, a range flag (cx<COLS && cy<ROWS) and display_on.
  - Stage 2 reads RAM.
  - rgb = RAM data when the delayed display_on and range flag are both 1, else 0.
  - Latency is exactly 2 clk from hpos/vpos to rgb.
- Read-during-write to the same address returns the old contents.
- Host write:
  - Handshake completes when wr_valid && wr_ready; the RAM is written that same edge.
  - wr_ready = (state==IDLE).
  - If wr_x>=COLS or wr_y>=ROWS, no write occurs and wr_err pulses high the next cycle.
  - wr_valid held while not ready simply waits; it is not lost.
- Fill FSM: IDLE -> FILL -> DONE -> IDLE.
  - IDLE: fill_start=1 latches fill_mode, fill_color and band_colors, and zeroes the x,y counters.
    - Enters FILL; fill_busy goes high the next cycle.
    - If fill_start and an accepted host write occur in the same cycle, the host write completes first, then the fill starts.
  - FILL: one cell per clk, x inner (0..COLS-1), y outer (0..ROWS-1); COLS*ROWS cycles total.
    - Mode 0 writes the latched fill_color.
    - Mode 1 writes the top band colour for y < ROWS/3, the middle colour for y < 2*(ROWS/3), else the bottom colour (integer division, constant).
    - After writing (COLS-1,ROWS-1) -> DONE.
  - DONE: fill_busy=0, fill_done=1 for one cycle -> IDLE.
  - fill_start during FILL or DONE is ignored.
  - Input changes after the start cycle have no effect on the running fill.
- rst_n asserted mid-fill: FSM returns to IDLE immediately, fill_done is not pulsed, RAM keeps a partial image, and scanout continues from the partial image.
- Counter widths are sized by $clog2 of COLS/ROWS; no wrap beyond the grid.

Test Plan:
- Reset, then fill_start with mode 0, fill_color=3'b101 -> fill_busy high for 4800 cycles, single fill_done pulse; scanning any visible pixel yields rgb=3'b101 two cycles later.
- Mode 1, band_colors={100,001,111} -> cell rows 0-19 read 111, rows 20-39 read 001, rows 40-59 read 100; probe pixel rows 159/160 and 319/320 at the band edges.
- Host write (x=79,y=59,color=010) -> hpos=632..639, vpos=472..479 give 010; write (x=80,y=0) -> wr_err pulse, RAM unchanged, no hang.
- wr_valid held during a fill -> wr_ready=0 until DONE, write lands after fill_done and is not overwritten; fill_start during FILL -> ignored, total cycle count still 4800.
- display_on=0, or hpos=700 (cx>=COLS) -> rgb=0 exactly 2 cycles later.
- rst_n low at fill cycle 1000 -> outputs zero asynchronously, cells 0..999 hold new colour, remainder old; a new fill then completes normally.
